// File: rtl/fp_mult_rr_sched_if.sv
// Request/response bundle between the filter/update engines (master) and the
// shared-multiplier scheduler (slave).
interface fp_mult_rr_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int W_len   = 16,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*W_len-1:0] req_a;
    logic [NUM_REQ*W_len-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [W_len-1:0]         rsp_product;
    logic                     rsp_overflow;
    logic                     rsp_underflow;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_underflow
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_product, rsp_overflow, rsp_underflow
    );
endinterface

// File: rtl/fp_mult_rr_sched.sv
// Round-robin scheduler sharing one registered Q-format multiplier among NUM_REQ
// requesters. Optional FP_MULT_SAT_EN saturates the product on a qualified flag.
module fp_mult #(
    parameter int W_len   = 16,
    parameter int W_fract = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [W_len-1:0] a,
    input  logic signed [W_len-1:0] b,
    output logic        [W_len-1:0] product,
    output logic                    overflow,
    output logic                    underflow
);
    localparam int HI_W = W_len - W_fract + 1;
    localparam int LO_W = W_len + W_fract - 1;
    localparam logic signed [2*W_len-1:0] PROD_MAX = {{HI_W{1'b0}}, {LO_W{1'b1}}};
    localparam logic signed [2*W_len-1:0] PROD_MIN = {{HI_W{1'b1}}, {LO_W{1'b0}}};

    logic signed [2*W_len-1:0] full_s;
    logic                      sign_s;

    assign full_s = a * b;
    // Sign comes from the operands, so zero times a negative reports underflow.
    assign sign_s = a[W_len-1] ^ b[W_len-1];

    // Truncate to the output Q format and register product plus range flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            product   <= {W_len{1'b0}};
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            product   <= full_s[W_len+W_fract-1:W_fract];
            overflow  <= ~sign_s & (full_s > PROD_MAX);
            underflow <= sign_s & ~((full_s < 0) & (full_s >= PROD_MIN));
        end
    end
endmodule

module fp_mult_rr_sched #(
    parameter int NUM_REQ = 4,
    parameter int W_len   = 16,
    parameter int W_fract = 14,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    fp_mult_rr_sched_if.slave   bus,
    output logic                busy
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [ID_W-1:0]    rr_ptr_r;
    logic [ID_W-1:0]    id_r;
    logic [W_len-1:0]   a_r;
    logic [W_len-1:0]   b_r;
    logic               rsp_valid_r;
    logic               busy_r;
    logic [ID_W-1:0]    grant_s;
    logic               grant_found_s;
    logic [ID_W-1:0]    ptr_next_s;
    logic [NUM_REQ-1:0] ready_s;
    logic [W_len-1:0]   mult_product_s;
    logic               mult_ovf_s;
    logic               mult_unf_s;
    logic               zero_op_s;
    logic               ovf_q_s;
    logic               unf_q_s;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] cand;
        grant_found_s = 1'b0;
        grant_s       = {ID_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_r} + k[ID_W:0];
            if (cand >= (ID_W+1)'(NUM_REQ)) begin
                cand = cand - (ID_W+1)'(NUM_REQ);
            end else begin
                cand = cand;
            end
            if (!grant_found_s && bus.req_valid[cand[ID_W-1:0]]) begin
                grant_found_s = 1'b1;
                grant_s       = cand[ID_W-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Pointer advances to the slot after the winner.
    always_comb begin
        logic [ID_W:0] nxt;
        nxt = {1'b0, grant_s} + {{ID_W{1'b0}}, 1'b1};
        if (nxt >= (ID_W+1)'(NUM_REQ)) begin
            ptr_next_s = {ID_W{1'b0}};
        end else begin
            ptr_next_s = nxt[ID_W-1:0];
        end
    end

    // Ready is only ever offered in IDLE, and only to the winner.
    always_comb begin
        ready_s = {NUM_REQ{1'b0}};
        if ((state_r == IDLE) && grant_found_s) begin
            ready_s[grant_s] = 1'b1;
        end else begin
            ready_s = {NUM_REQ{1'b0}};
        end
    end

    // IDLE -> MUL on a grant, MUL -> RESP always, RESP -> IDLE on consume.
    always_comb begin
        case (state_r)
            IDLE:    state_next_s = grant_found_s ? MUL : IDLE;
            MUL:     state_next_s = RESP;
            RESP:    state_next_s = bus.rsp_ready ? IDLE : RESP;
            default: state_next_s = IDLE;
        endcase
    end

    // State, arbitration pointer, captured operands and registered status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {ID_W{1'b0}};
            id_r        <= {ID_W{1'b0}};
            a_r         <= {W_len{1'b0}};
            b_r         <= {W_len{1'b0}};
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            rsp_valid_r <= (state_next_s == RESP);
            busy_r      <= (state_next_s != IDLE);
            if ((state_r == IDLE) && grant_found_s) begin
                a_r      <= bus.req_a[grant_s*W_len +: W_len];
                b_r      <= bus.req_b[grant_s*W_len +: W_len];
                id_r     <= grant_s;
                rr_ptr_r <= ptr_next_s;
            end else begin
                a_r      <= a_r;
                b_r      <= b_r;
                id_r     <= id_r;
                rr_ptr_r <= rr_ptr_r;
            end
        end
    end

    fp_mult #(
        .W_len   (W_len),
        .W_fract (W_fract)
    ) u_fp_mult (
        .clk       (clk),
        .reset     (reset),
        .a         (a_r),
        .b         (b_r),
        .product   (mult_product_s),
        .overflow  (mult_ovf_s),
        .underflow (mult_unf_s)
    );

    // a_r/b_r stay put through RESP, so the multiplier output is stable there.
    assign zero_op_s = (a_r == {W_len{1'b0}}) | (b_r == {W_len{1'b0}});
    assign ovf_q_s   = mult_ovf_s & ~zero_op_s;
    assign unf_q_s   = mult_unf_s & ~zero_op_s;

    // Product presented to the consumer, optionally clamped on a range flag.
    always_comb begin
`ifdef FP_MULT_SAT_EN
        if (ovf_q_s) begin
            bus.rsp_product = {1'b0, {(W_len-1){1'b1}}};
        end else if (unf_q_s) begin
            bus.rsp_product = {1'b1, {(W_len-1){1'b0}}};
        end else begin
            bus.rsp_product = mult_product_s;
        end
`else
        bus.rsp_product = mult_product_s;
`endif
    end

    assign bus.req_ready     = ready_s;
    assign bus.rsp_valid     = rsp_valid_r;
    assign bus.rsp_id        = id_r;
    assign bus.rsp_overflow  = ovf_q_s;
    assign bus.rsp_underflow = unf_q_s;
    assign busy              = busy_r;
endmodule

// File: tb/tb_fp_mult_rr_sched.sv
// Directed self-checking bench for fp_mult_rr_sched; expectations follow the
// FP_MULT_SAT_EN setting of the build.
module tb_fp_mult_rr_sched;
    localparam int NUM_REQ = 4;
    localparam int W_len   = 16;
    localparam int W_fract = 14;
    localparam int ID_W    = 2;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   n_tests = 0;
    int   n_fail  = 0;

    fp_mult_rr_sched_if #(.NUM_REQ(NUM_REQ), .W_len(W_len), .ID_W(ID_W)) bus ();

    fp_mult_rr_sched #(
        .NUM_REQ (NUM_REQ),
        .W_len   (W_len),
        .W_fract (W_fract),
        .ID_W    (ID_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]          = 1'b1;
        bus.req_a[i*W_len +: W_len] = a;
        bus.req_b[i*W_len +: W_len] = b;
    endtask

    // One isolated operation; entered and left just after a negedge in IDLE.
    task automatic do_op(input string tag, input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_p, input logic exp_ov, input logic exp_un);
        bus.req_valid = 4'b0000;
        set_req(i, a, b);
        #1 check_eq({tag, ":ready"}, 32'(bus.req_ready), 32'(4'b0001 << i));
        @(negedge clk);
        bus.req_valid = 4'b0000;
        check_eq({tag, ":mul_valid"}, 32'(bus.rsp_valid), 32'(1'b0));
        check_eq({tag, ":mul_busy"}, 32'(busy), 32'(1'b1));
        @(negedge clk);
        check_eq({tag, ":valid"}, 32'(bus.rsp_valid), 32'(1'b1));
        check_eq({tag, ":id"}, 32'(bus.rsp_id), 32'(i));
        check_eq({tag, ":product"}, 32'(bus.rsp_product), 32'(exp_p));
        check_eq({tag, ":ovf"}, 32'(bus.rsp_overflow), 32'(exp_ov));
        check_eq({tag, ":unf"}, 32'(bus.rsp_underflow), 32'(exp_un));
        @(negedge clk);
        check_eq({tag, ":done_valid"}, 32'(bus.rsp_valid), 32'(1'b0));
        check_eq({tag, ":done_busy"}, 32'(busy), 32'(1'b0));
    endtask

    initial begin
        logic [15:0] ovf_p;
        logic [15:0] unf_p;
        logic [15:0] a_tab [NUM_REQ];
`ifdef FP_MULT_SAT_EN
        ovf_p = 16'h7FFF;
        unf_p = 16'h8000;
`else
        ovf_p = 16'hFFFC;
        unf_p = 16'h0002;
`endif
        reset         = 1'b1;
        bus.req_valid = 4'b0000;
        bus.req_a     = 64'h0;
        bus.req_b     = 64'h0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst:ready", 32'(bus.req_ready), 32'(4'b0000));
        check_eq("rst:valid", 32'(bus.rsp_valid), 32'(1'b0));
        check_eq("rst:id", 32'(bus.rsp_id), 32'(2'd0));
        check_eq("rst:product", 32'(bus.rsp_product), 32'(16'h0000));
        check_eq("rst:flags", 32'({bus.rsp_overflow, bus.rsp_underflow}), 32'(2'b00));
        check_eq("rst:busy", 32'(busy), 32'(1'b0));
        reset = 1'b0;
        @(negedge clk);

        do_op("half",  1, 16'h2000, 16'h2000, 16'h1000, 1'b0, 1'b0);
        do_op("ovf",   0, 16'h7FFF, 16'h7FFF, ovf_p,    1'b1, 1'b0);
        do_op("unf",   2, 16'h7FFF, 16'h8000, unf_p,    1'b0, 1'b1);
        do_op("zero",  3, 16'h0000, 16'hC000, 16'h0000, 1'b0, 1'b0);
        do_op("neg",   1, 16'hE000, 16'h2000, 16'hF000, 1'b0, 1'b0);
        do_op("trunc", 2, 16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 1'b0);

        // Round robin from a fresh reset with every requester pending.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            a_tab[i] = 16'((i + 1) * 16'h1000);
            set_req(i, a_tab[i], 16'h4000);
        end
        for (int k = 0; k < 5; k++) begin
            #1 check_eq($sformatf("rr%0d:ready", k), 32'(bus.req_ready), 32'(4'b0001 << (k % NUM_REQ)));
            @(negedge clk);
            check_eq($sformatf("rr%0d:mul_valid", k), 32'(bus.rsp_valid), 32'(1'b0));
            @(negedge clk);
            check_eq($sformatf("rr%0d:valid", k), 32'(bus.rsp_valid), 32'(1'b1));
            check_eq($sformatf("rr%0d:id", k), 32'(bus.rsp_id), 32'(k % NUM_REQ));
            check_eq($sformatf("rr%0d:product", k), 32'(bus.rsp_product), 32'(a_tab[k % NUM_REQ]));
            check_eq($sformatf("rr%0d:resp_ready", k), 32'(bus.req_ready), 32'(4'b0000));
            @(negedge clk);
        end

        // Backpressure: the next winner is requester 1, held in RESP.
        bus.rsp_ready = 1'b0;
        #1 check_eq("bp:grant", 32'(bus.req_ready), 32'(4'b0010));
        @(negedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check_eq($sformatf("bp%0d:valid", c), 32'(bus.rsp_valid), 32'(1'b1));
            check_eq($sformatf("bp%0d:id", c), 32'(bus.rsp_id), 32'(2'd1));
            check_eq($sformatf("bp%0d:product", c), 32'(bus.rsp_product), 32'(16'h2000));
            check_eq($sformatf("bp%0d:ready", c), 32'(bus.req_ready), 32'(4'b0000));
            check_eq($sformatf("bp%0d:busy", c), 32'(busy), 32'(1'b1));
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        #1 check_eq("bp:next_grant", 32'(bus.req_ready), 32'(4'b0100));

        // Reset while requester 2 is in MUL: no response, pointer back to 0.
        @(negedge clk);
        check_eq("mrst:pre_busy", 32'(busy), 32'(1'b1));
        reset         = 1'b1;
        bus.req_valid = 4'b0000;
        #1;
        check_eq("mrst:busy", 32'(busy), 32'(1'b0));
        check_eq("mrst:valid", 32'(bus.rsp_valid), 32'(1'b0));
        check_eq("mrst:id", 32'(bus.rsp_id), 32'(2'd0));
        check_eq("mrst:product", 32'(bus.rsp_product), 32'(16'h0000));
        check_eq("mrst:ready", 32'(bus.req_ready), 32'(4'b0000));
        @(negedge clk);
        check_eq("mrst:held_valid", 32'(bus.rsp_valid), 32'(1'b0));
        reset = 1'b0;
        set_req(0, 16'h2000, 16'h2000);
        set_req(3, 16'h2000, 16'h4000);
        #1 check_eq("mrst:ptr0", 32'(bus.req_ready), 32'(4'b0001));
        @(negedge clk);
        bus.req_valid = 4'b0000;
        check_eq("mrst:mul_valid", 32'(bus.rsp_valid), 32'(1'b0));
        @(negedge clk);
        check_eq("mrst:id0", 32'(bus.rsp_id), 32'(2'd0));
        check_eq("mrst:prod0", 32'(bus.rsp_product), 32'(16'h1000));
        @(negedge clk);
        do_op("after_rst", 3, 16'h2000, 16'h4000, 16'h2000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
